// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - shared widths, op encoding and FSM states for the divider issue controller
package div_issue_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam int OP_DIV  = 0;
  localparam int OP_MOD  = 1;
  localparam int OP_DIVU = 2;
  localparam int OP_MODU = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } div_state_e;

  // Signed unit for div/mod; the unsigned bits also gate it so a malformed op never picks both.
  function automatic logic op_is_signed(input logic [3:0] op);
    return (op[OP_DIV] | op[OP_MOD]) & ~(op[OP_DIVU] | op[OP_MODU]);
  endfunction

  function automatic logic op_is_quot(input logic [3:0] op);
    return op[OP_DIV] | op[OP_DIVU];
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - EX request/result and divider IP stream signals
interface div_issue_ctrl_if;
  import div_issue_ctrl_pkg::*;

  logic                  req_valid;
  logic [3:0]            req_op;
  logic [DATA_W-1:0]     req_src1;
  logic [DATA_W-1:0]     req_src2;
  logic                  req_ready;
  logic                  flush;
  logic                  res_valid;
  logic [DATA_W-1:0]     res_data;
  logic                  res_ack;
  logic [DATA_W-1:0]     div_src1;
  logic [DATA_W-1:0]     div_src2;
  logic                  s_dvd_tvalid;
  logic                  s_dvs_tvalid;
  logic                  s_dvd_tready;
  logic                  s_dvs_tready;
  logic                  s_dout_tvalid;
  logic [2*DATA_W-1:0]   s_dout_tdata;
  logic                  u_dvd_tvalid;
  logic                  u_dvs_tvalid;
  logic                  u_dvd_tready;
  logic                  u_dvs_tready;
  logic                  u_dout_tvalid;
  logic [2*DATA_W-1:0]   u_dout_tdata;

  modport master (
    output req_valid, req_op, req_src1, req_src2, flush, res_ack,
           s_dvd_tready, s_dvs_tready, s_dout_tvalid, s_dout_tdata,
           u_dvd_tready, u_dvs_tready, u_dout_tvalid, u_dout_tdata,
    input  req_ready, res_valid, res_data, div_src1, div_src2,
           s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush, res_ack,
           s_dvd_tready, s_dvs_tready, s_dout_tvalid, s_dout_tdata,
           u_dvd_tready, u_dvs_tready, u_dout_tvalid, u_dout_tdata,
    output req_ready, res_valid, res_data, div_src1, div_src2,
           s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid
  );

endinterface

// File: rtl/div_issue_ctrl_axis_issue_ch.sv
// rtl/div_issue_ctrl_axis_issue_ch.sv - one stream channel: hold tvalid until tready, then flag done
module axis_issue_ch (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_cancel,
  input  logic i_tready,
  output logic o_tvalid,
  output logic o_done
);

  logic r_tvalid;
  logic r_done;

  // Cancel is only raised by the parent while this channel has not handshaken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tvalid <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_start) begin
      r_tvalid <= 1'b1;
      r_done   <= 1'b0;
    end else if (i_cancel) begin
      r_tvalid <= 1'b0;
    end else if (r_tvalid && i_tready) begin
      r_tvalid <= 1'b0;
      r_done   <= 1'b1;
    end
  end

  assign o_tvalid = r_tvalid;
  assign o_done   = r_done;

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - sequences one div/mod op through the shared signed/unsigned divider IPs
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  div_issue_ctrl_if.slave    bus
);

  div_state_e          r_state;
  logic                r_signed;
  logic                r_quot;
  logic                r_flushed;
  logic [DATA_W-1:0]   r_src1;
  logic [DATA_W-1:0]   r_src2;
  logic [DATA_W-1:0]   r_res_data;
  logic                r_res_valid;

  logic                w_accept;
  logic                w_cancel;
  logic                w_dvd_tvalid, w_dvs_tvalid;
  logic                w_dvd_done, w_dvs_done;
  logic                w_dvd_tready, w_dvs_tready;
  logic                w_dvd_fin, w_dvs_fin;
  logic                w_dout_tvalid;
  logic [2*DATA_W-1:0] w_dout_tdata;
  logic [DATA_W-1:0]   w_res_sel;

  assign w_accept      = ~reset & (r_state == ST_IDLE) & bus.req_valid & ~bus.flush;
  assign w_dvd_tready  = r_signed ? bus.s_dvd_tready : bus.u_dvd_tready;
  assign w_dvs_tready  = r_signed ? bus.s_dvs_tready : bus.u_dvs_tready;
  assign w_dvd_fin     = w_dvd_done | (w_dvd_tvalid & w_dvd_tready);
  assign w_dvs_fin     = w_dvs_done | (w_dvs_tvalid & w_dvs_tready);
  // Once either channel has handshaken, the partner must complete; only a clean op may be withdrawn.
  assign w_cancel      = (r_state == ST_ISSUE) & bus.flush & ~(w_dvd_fin | w_dvs_fin);
  assign w_dout_tvalid = r_signed ? bus.s_dout_tvalid : bus.u_dout_tvalid;
  assign w_dout_tdata  = r_signed ? bus.s_dout_tdata  : bus.u_dout_tdata;
  assign w_res_sel     = r_quot ? w_dout_tdata[2*DATA_W-1:DATA_W] : w_dout_tdata[DATA_W-1:0];

  axis_issue_ch u_dvd_ch (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept),
    .i_cancel (w_cancel),
    .i_tready (w_dvd_tready),
    .o_tvalid (w_dvd_tvalid),
    .o_done   (w_dvd_done)
  );

  axis_issue_ch u_dvs_ch (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept),
    .i_cancel (w_cancel),
    .i_tready (w_dvs_tready),
    .o_tvalid (w_dvs_tvalid),
    .o_done   (w_dvs_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_signed    <= 1'b0;
      r_quot      <= 1'b0;
      r_flushed   <= 1'b0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_signed  <= op_is_signed(bus.req_op);
            r_quot    <= op_is_quot(bus.req_op);
            r_src1    <= bus.req_src1;
            r_src2    <= bus.req_src2;
            r_flushed <= 1'b0;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_cancel) begin
            r_state <= ST_IDLE;
          end else begin
            if (bus.flush) r_flushed <= 1'b1;
            if (w_dvd_fin && w_dvs_fin)
              r_state <= (r_flushed || bus.flush) ? ST_DRAIN : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.flush) begin
            r_state <= w_dout_tvalid ? ST_IDLE : ST_DRAIN;
          end else if (w_dout_tvalid) begin
            r_res_data  <= w_res_sel;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.flush || bus.res_ack) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_dout_tvalid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = w_accept;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.div_src1     = r_src1;
  assign bus.div_src2     = r_src2;
  assign bus.s_dvd_tvalid = w_dvd_tvalid &  r_signed;
  assign bus.s_dvs_tvalid = w_dvs_tvalid &  r_signed;
  assign bus.u_dvd_tvalid = w_dvd_tvalid & ~r_signed;
  assign bus.u_dvs_tvalid = w_dvs_tvalid & ~r_signed;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - randomized bench for div_issue_ctrl with a divider IP model and arithmetic reference
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_issue_ctrl_if bus();

  div_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // IP model knobs and observations
  bit          rnd_mode = 0;
  bit          noise = 0;
  int          dvd_wait = 0, dvs_wait = 0, lat = 10;
  int          cur_dvd_wait = 0, cur_dvs_wait = 0;
  int          dvd_cnt = 0, dvs_cnt = 0, lat_cnt = 0;
  bit          dvd_got = 0, dvs_got = 0, dvd_sgn = 0, dvs_sgn = 0, pend_sgn = 0;
  logic [31:0] dvd_val, dvs_val;
  logic [63:0] pend;
  int          dout_cyc = -1, prev_dout_cyc = -1;
  int          dvd_run = 0, dvs_run = 0, dvd_len = 0, dvs_len = 0;
  bit          s_seen = 0, u_seen = 0;
  int          proto_err = 0;
  int          acc_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behaviour of the divider IPs themselves, including their divide-by-zero output.
  function automatic logic [63:0] ip_calc(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      q  = 32'(ua / ub);
      r  = 32'(ua % ub);
    end
    return {q, r};
  endfunction

  // What EX should receive for an op: truncating quotient, remainder as n - q*d.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint n, d, q;
    bit sgn, want_q;
    sgn    = op[OP_DIV] | op[OP_MOD];
    want_q = op[OP_DIV] | op[OP_DIVU];
    if (b == 32'd0) return want_q ? 32'hFFFF_FFFF : a;
    n = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    d = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q = n / d;
    return want_q ? 32'(q) : 32'(n - q * d);
  endfunction

  // Divider IP model: acts just after each rising edge so its inputs are stable for the next one.
  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      dvd_cnt = 0; dvs_cnt = 0; lat_cnt = 0; dvd_got = 0; dvs_got = 0;
      dvd_run = 0; dvs_run = 0;
      bus.s_dvd_tready = 0; bus.s_dvs_tready = 0; bus.u_dvd_tready = 0; bus.u_dvs_tready = 0;
      bus.s_dout_tvalid = 0; bus.u_dout_tvalid = 0;
    end else begin
      bus.s_dout_tvalid = 0;
      bus.u_dout_tvalid = 0;
      bus.s_dout_tdata  = {$urandom, $urandom};
      bus.u_dout_tdata  = {$urandom, $urandom};
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          if (pend_sgn) begin bus.s_dout_tvalid = 1; bus.s_dout_tdata = pend; end
          else          begin bus.u_dout_tvalid = 1; bus.u_dout_tdata = pend; end
          prev_dout_cyc = dout_cyc;
          dout_cyc      = cyc + 1;
        end else if (noise && $urandom_range(0, 3) == 0) begin
          if (pend_sgn) bus.u_dout_tvalid = 1;
          else          bus.s_dout_tvalid = 1;
        end
      end
      if (bus.s_dvd_tvalid | bus.s_dvs_tvalid) s_seen = 1;
      if (bus.u_dvd_tvalid | bus.u_dvs_tvalid) u_seen = 1;
      if ((bus.s_dvd_tvalid | bus.u_dvd_tvalid | bus.s_dvs_tvalid | bus.u_dvs_tvalid) && lat_cnt > 0)
        proto_err++;
      if (bus.s_dvd_tvalid | bus.u_dvd_tvalid) dvd_run++;
      else if (dvd_run > 0) begin dvd_len = dvd_run; dvd_run = 0; end
      if (bus.s_dvs_tvalid | bus.u_dvs_tvalid) dvs_run++;
      else if (dvs_run > 0) begin dvs_len = dvs_run; dvs_run = 0; end

      bus.s_dvd_tready = rnd_mode ? 1'($urandom) : 1'b0;
      bus.u_dvd_tready = rnd_mode ? 1'($urandom) : 1'b0;
      if (bus.s_dvd_tvalid | bus.u_dvd_tvalid) begin
        if (dvd_got) proto_err++;
        if (dvd_cnt == 0) cur_dvd_wait = rnd_mode ? $urandom_range(0, 3) : dvd_wait;
        if (bus.s_dvd_tvalid) bus.s_dvd_tready = (dvd_cnt >= cur_dvd_wait);
        else                  bus.u_dvd_tready = (dvd_cnt >= cur_dvd_wait);
        if (dvd_cnt >= cur_dvd_wait) begin
          dvd_got = 1; dvd_val = bus.div_src1; dvd_sgn = bus.s_dvd_tvalid; dvd_cnt = 0;
        end else dvd_cnt++;
      end else dvd_cnt = 0;

      bus.s_dvs_tready = rnd_mode ? 1'($urandom) : 1'b0;
      bus.u_dvs_tready = rnd_mode ? 1'($urandom) : 1'b0;
      if (bus.s_dvs_tvalid | bus.u_dvs_tvalid) begin
        if (dvs_got) proto_err++;
        if (dvs_cnt == 0) cur_dvs_wait = rnd_mode ? $urandom_range(0, 3) : dvs_wait;
        if (bus.s_dvs_tvalid) bus.s_dvs_tready = (dvs_cnt >= cur_dvs_wait);
        else                  bus.u_dvs_tready = (dvs_cnt >= cur_dvs_wait);
        if (dvs_cnt >= cur_dvs_wait) begin
          dvs_got = 1; dvs_val = bus.div_src2; dvs_sgn = bus.s_dvs_tvalid; dvs_cnt = 0;
        end else dvs_cnt++;
      end else dvs_cnt = 0;

      if (dvd_got && dvs_got) begin
        if (dvd_sgn != dvs_sgn) proto_err++;
        pend     = ip_calc(dvd_val, dvs_val, dvd_sgn);
        pend_sgn = dvd_sgn;
        lat_cnt  = rnd_mode ? $urandom_range(1, 8) : lat;
        dvd_got  = 0;
        dvs_got  = 0;
      end
    end
  end

  task automatic send_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int t;
    @(negedge clk);
    bus.req_op = op; bus.req_src1 = a; bus.req_src2 = b; bus.req_valid = 1;
    #1;
    t = 0;
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("accept_timeout", 64'(t < 200), 64'd1);
    acc_cyc = cyc;
    s_seen  = 0;
    u_seen  = 0;
    @(negedge clk);
    bus.req_valid = 0;
    bus.req_op    = 4'($urandom);
    bus.req_src1  = $urandom;
    bus.req_src2  = $urandom;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int flush_at, input int ack_wait);
    int t;
    bit done, sgn;
    sgn = op[OP_DIV] | op[OP_MOD];
    send_req(op, a, b);
    check("tvalid_t1", sgn ? {bus.s_dvd_tvalid, bus.s_dvs_tvalid} : {bus.u_dvd_tvalid, bus.u_dvs_tvalid}, 2'b11);
    t = 0;
    done = 0;
    while (!done && t < 400) begin
      if (flush_at >= 0 && t == flush_at) begin
        bus.flush = 1;
        @(negedge clk);
        bus.flush = 0;
        check("flush_res_valid", bus.res_valid, 1'b0);
        done = 1;
      end else if (bus.res_valid) begin
        check("res_data", bus.res_data, exp);
        check("res_latency", cyc, dout_cyc);
        repeat (ack_wait) begin
          @(negedge clk);
          check("hold_valid", bus.res_valid, 1'b1);
          check("hold_data", bus.res_data, exp);
        end
        bus.res_ack = 1;
        @(negedge clk);
        bus.res_ack = 0;
        check("ack_drop", bus.res_valid, 1'b0);
        done = 1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    check("op_timeout", done, 1'b1);
    check("unit_select", {s_seen, u_seen}, sgn ? 2'b10 : 2'b01);
    check("protocol", proto_err, 0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          seen_rv;
    bus.req_valid = 0; bus.req_op = 0; bus.req_src1 = 0; bus.req_src2 = 0;
    bus.flush = 0; bus.res_ack = 0;
    bus.s_dvd_tready = 0; bus.s_dvs_tready = 0; bus.u_dvd_tready = 0; bus.u_dvs_tready = 0;
    bus.s_dout_tvalid = 0; bus.u_dout_tvalid = 0; bus.s_dout_tdata = 0; bus.u_dout_tdata = 0;
    reset = 1;
    bus.req_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_tvalids", {bus.s_dvd_tvalid, bus.s_dvs_tvalid, bus.u_dvd_tvalid, bus.u_dvs_tvalid}, 4'b0);
    check("rst_regs", {bus.div_src1, bus.div_src2}, 64'd0);
    bus.req_valid = 0;
    @(negedge clk);
    reset = 0;

    // div 100/7, immediate tready, result 10 cycles later
    dvd_wait = 0; dvs_wait = 0; lat = 10;
    do_op(4'b0001, 32'd100, 32'd7, 32'd14, -1, 3);

    // modu 0xFFFFFFFF/16 with staggered tready
    dvd_wait = 0; dvs_wait = 2; lat = 4;
    do_op(4'b1000, 32'hFFFF_FFFF, 32'd16, 32'd15, -1, 1);
    check("t2_dvd_len", dvd_len, 1);
    check("t2_dvs_len", dvs_len, 3);

    // mod -7/2 on the signed unit
    dvd_wait = 0; dvs_wait = 0; lat = 3;
    do_op(4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1, 0);

    // flush after dividend only: divisor still issued, result swallowed
    dvd_wait = 0; dvs_wait = 4; lat = 10;
    do_op(4'b0001, 32'd1000, 32'd3, 32'd333, 2, 0);
    seen_rv = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.res_valid) seen_rv++;
    end
    check("t4_no_res", seen_rv, 0);
    check("t4_dvs_len", dvs_len, 5);
    dvs_wait = 0;
    do_op(4'b0001, 32'd50, 32'd5, 32'd10, -1, 0);

    // flush in WAIT, then divu 9/3 must wait for the stale result to drain
    lat = 10;
    do_op(4'b0001, 32'd8, 32'd2, 32'd4, 4, 0);
    do_op(4'b0100, 32'd9, 32'd3, 32'd3, -1, 0);
    check("t5_accept_after_drain", acc_cyc, prev_dout_cyc);

    // reset while holding a result
    lat = 3;
    send_req(4'b0001, 32'd20, 32'd4);
    begin
      int t;
      t = 0;
      while (!bus.res_valid && t < 100) begin @(negedge clk); t++; end
      check("t6_reach_done", bus.res_valid, 1'b1);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("t6_res_valid", bus.res_valid, 1'b0);
    check("t6_res_data", bus.res_data, 32'd0);
    check("t6_tvalids", {bus.s_dvd_tvalid, bus.s_dvs_tvalid, bus.u_dvd_tvalid, bus.u_dvs_tvalid}, 4'b0);
    bus.req_valid = 1;
    #1;
    check("t6_idle_ready", bus.req_ready, 1'b1);
    bus.req_valid = 0;

    // randomized traffic with random handshakes, latencies, flushes and stray results
    rnd_mode = 1;
    noise    = 1;
    for (int i = 0; i < 60; i++) begin
      op = 4'b0001 << $urandom_range(0, 3);
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 9);
        3:       b = -$urandom_range(1, 9);
        default: b = $urandom;
      endcase
      do_op(op, a, b, ref_res(op, a, b),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1,
            $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
